// File: rtl/tiny_cpu_sequencer.sv
// rtl/tiny_cpu_sequencer.sv - program store and timed instruction issue for TinyCPU
// Optional macro SEQ_SINGLE_STEP_EN: HOLD ends on an external Step pulse instead of the counter.
module tiny_cpu_sequencer #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ProgWe,
  input  logic [ADDR_W-1:0] ProgAddr,
  input  logic [11:0]       ProgData,
  input  logic [ADDR_W:0]   ProgLen,
  input  logic              Start,
  input  logic              Abort,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              Step,
`endif
  input  logic [7:0]        Result,
  output logic [11:0]       Instr,
  output logic              InstrValid,
  output logic [ADDR_W-1:0] Pc,
  output logic              Busy,
  output logic              Done,
  output logic [7:0]        LastResult,
  output logic [ADDR_W:0]   IssueCount
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  state_t            state, state_n;
  logic [11:0]       mem [DEPTH];
  logic [11:0]       word;
  logic [ADDR_W:0]   len, len_n, issue_n;
  logic [11:0]       instr_n;
  logic              valid_n;
  logic [ADDR_W-1:0] pc_n;
  logic [7:0]        last_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              hold_last;

  assign word = mem[Pc];
  assign Busy = (state == FETCH) || (state == HOLD);
  assign Done = (state == DONE);

`ifdef SEQ_SINGLE_STEP_EN
  assign hold_last = Step;
`else
  assign hold_last = (cnt == '0);
`endif

  always_comb begin
    state_n = state;
    len_n   = len;
    instr_n = Instr;
    valid_n = InstrValid;
    pc_n    = Pc;
    last_n  = LastResult;
    issue_n = IssueCount;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (Start) begin
          if (ProgLen == '0) begin
            state_n = DONE;
          end else begin
            len_n   = (ProgLen > DEPTH_L) ? DEPTH_L : ProgLen;
            pc_n    = '0;
            issue_n = '0;
            state_n = FETCH;
          end
        end
      end
      FETCH: begin
        // HALT ends the run without ever reaching the CPU bus
        if (word[11:8] == 4'hF) begin
          state_n = DONE;
        end else begin
          instr_n = word;
          valid_n = 1'b1;
          cnt_n   = CNT_INIT;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (hold_last) begin
          last_n  = Result;
          issue_n = IssueCount + 1'b1;
          valid_n = 1'b0;
          if ({1'b0, Pc} == len - (ADDR_W+1)'(1)) begin
            state_n = DONE;
          end else begin
            pc_n    = Pc + 1'b1;
            state_n = FETCH;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Abort overrides whatever the run would have done this cycle
    if (Abort && ((state == FETCH) || (state == HOLD))) begin
      state_n = IDLE;
      instr_n = '0;
      valid_n = 1'b0;
      pc_n    = Pc;
      last_n  = LastResult;
      issue_n = IssueCount;
      cnt_n   = cnt;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      len        <= '0;
      Instr      <= '0;
      InstrValid <= 1'b0;
      Pc         <= '0;
      LastResult <= '0;
      IssueCount <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_n;
      len        <= len_n;
      Instr      <= instr_n;
      InstrValid <= valid_n;
      Pc         <= pc_n;
      LastResult <= last_n;
      IssueCount <= issue_n;
      cnt        <= cnt_n;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && (state == IDLE) && ProgWe) begin
      mem[ProgAddr] <= ProgData;
    end
  end

endmodule

// File: tb/tb_tiny_cpu_sequencer.sv
// tb/tb_tiny_cpu_sequencer.sv - directed bench with a schedule-based model of the issue sequence
module tb_tiny_cpu_sequencer;
  localparam int H = 4;
  localparam int P = H + 1;
  localparam int M_RST = 0, M_RUN = 1, M_ABT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [11:0] prog_data = '0;
  logic [4:0]  prog_len = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        step = 1'b0;
  logic [7:0]  result;
  logic [11:0] instr;
  logic        instr_valid;
  logic [3:0]  pc;
  logic        busy;
  logic        done;
  logic [7:0]  last_result;
  logic [4:0]  issue_count;

  // stub CPU: Result echoes the opcode of the word on the bus
  assign result = {4'h0, instr[11:8]};

  tiny_cpu_sequencer #(.DEPTH(16), .ADDR_W(4), .HOLD_CYCLES(H)) dut (
`ifdef SEQ_SINGLE_STEP_EN
    .Step(step),
`endif
    .Clk(clk), .Reset(reset), .ProgWe(prog_we), .ProgAddr(prog_addr), .ProgData(prog_data),
    .ProgLen(prog_len), .Start(start), .Abort(abort), .Result(result), .Instr(instr),
    .InstrValid(instr_valid), .Pc(pc), .Busy(busy), .Done(done), .LastResult(last_result),
    .IssueCount(issue_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total_cnt = 0, pass_cnt = 0, done_seen = 0;
  bit chk_en = 1'b0;
  int mode = M_RST;
  int t0, run_n, halt_idx;
  logic [11:0] prog [16];
  logic [11:0] p_instr, ab_instr, e_instr;
  logic [3:0]  p_pc, ab_pc, e_pc;
  logic [4:0]  p_issue, ab_issue, e_issue;
  logic [7:0]  p_last, ab_last, e_last;
  logic        e_valid, e_busy, e_done;

  function automatic logic [7:0] res_of(input logic [11:0] w);
    return {4'h0, w[11:8]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // expected outputs from the issue schedule: instruction i owns cycles i*P .. i*P+H after Start
  int t, i, ph, ne, endt;
  always @(negedge clk) begin
    if (chk_en) begin
      e_instr = '0; e_valid = 0; e_busy = 0; e_done = 0; e_pc = '0; e_issue = '0; e_last = '0;
      if (mode == M_ABT) begin
        e_pc = ab_pc; e_issue = ab_issue; e_last = ab_last;
      end else if (mode == M_RUN) begin
        t    = cyc - t0;
        ne   = (halt_idx >= 0) ? halt_idx : run_n;
        endt = (halt_idx >= 0) ? halt_idx * P + 1 : run_n * P;
        if (t < endt) begin
          i = t / P; ph = t % P;
          e_busy  = 1; e_pc = 4'(i); e_issue = 5'(i);
          e_last  = (i == 0) ? p_last : res_of(prog[i-1]);
          e_valid = (ph != 0);
          e_instr = (ph != 0) ? prog[i] : ((i == 0) ? p_instr : prog[i-1]);
        end else begin
          e_done  = (t == endt);
          e_instr = (ne == 0) ? p_instr : prog[ne-1];
          e_last  = (ne == 0) ? p_last : res_of(prog[ne-1]);
          e_pc    = (run_n == 0) ? p_pc : ((halt_idx >= 0) ? 4'(halt_idx) : 4'(run_n - 1));
          e_issue = (run_n == 0) ? p_issue : 5'(ne);
        end
      end
      if (done) done_seen++;
      chk("instr", instr, e_instr);
      chk("instr_valid", instr_valid, e_valid);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("pc", pc, e_pc);
      chk("issue_count", issue_count, e_issue);
      chk("last_result", last_result, e_last);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [11:0] d, input bit upd);
    prog_we = 1; prog_addr = 4'(a); prog_data = d;
    tick();
    prog_we = 0;
    if (upd) prog[a] = d;
  endtask

  task automatic start_run(input int len);
    start = 1; prog_len = 5'(len);
    tick();
    start = 0;
    p_instr = e_instr; p_pc = e_pc; p_issue = e_issue; p_last = e_last;
    mode = M_RUN; t0 = cyc;
    run_n = (len > 16) ? 16 : len;
    halt_idx = -1;
    for (int k = 0; k < run_n; k++)
      if (halt_idx < 0 && prog[k][11:8] == 4'hF) halt_idx = k;
  endtask

  task automatic do_abort();
    abort = 1;
    tick();
    abort = 0;
    ab_pc = e_pc; ab_issue = e_issue; ab_last = e_last;
    mode = M_ABT;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
    mode = M_RST;
  endtask

  int d0;
  logic [11:0] base [8];
  initial begin
    base[0] = 12'h000; base[1] = 12'h107; base[2] = 12'h208; base[3] = 12'h400;
    base[4] = 12'h900; base[5] = 12'hB00; base[6] = 12'h600; base[7] = 12'h300;
    repeat (2) tick();
    reset = 0;
    chk_en = 1;
    chk("reset_instr", instr, 12'h000);
    chk("reset_issue", issue_count, 5'd0);
    for (int k = 0; k < 8; k++) wr(k, base[k], 1);
    for (int k = 8; k < 16; k++) wr(k, 12'h1A0 + 12'(k), 1);

    // full program
    d0 = done_seen;
    start_run(8);
    repeat (42) tick();
    chk("t1_issue", issue_count, 5'd8);
    chk("t1_last", last_result, 8'h03);
    chk("t1_instr", instr, 12'h300);
    chk("t1_done_pulses", done_seen - d0, 1);

    // HALT at entry 2
    wr(2, 12'hF00, 1);
    d0 = done_seen;
    start_run(8);
    repeat (14) tick();
    chk("t2_issue", issue_count, 5'd2);
    chk("t2_instr", instr, 12'h107);
    chk("t2_done_pulses", done_seen - d0, 1);
    wr(2, 12'h208, 1);

    // zero-length run
    start_run(0);
    chk("t3_done", done, 1'b1);
    tick();
    chk("t3_done_gone", done, 1'b0);

    // abort in the second cycle of the third hold
    d0 = done_seen;
    start_run(8);
    repeat (12) tick();
    do_abort();
    chk("t4_instr", instr, 12'h000);
    chk("t4_valid", instr_valid, 1'b0);
    chk("t4_busy", busy, 1'b0);
    repeat (3) tick();
    chk("t4_no_done", done_seen - d0, 0);
    start_run(8);
    tick();
    chk("t4_restart_valid", instr_valid, 1'b1);
    chk("t4_restart_pc", pc, 4'd0);
    repeat (42) tick();

    // write during a run is dropped, then reset mid-hold
    start_run(8);
    tick();
    wr(0, 12'hABC, 0);
    repeat (42) tick();
    start_run(8);
    tick();
    chk("t5_word0", instr, 12'h000);
    repeat (7) tick();
    do_reset();
    chk("t5_rst_pc", pc, 4'd0);
    chk("t5_rst_last", last_result, 8'h00);
    chk("t5_rst_issue", issue_count, 5'd0);
    chk("t5_rst_valid", instr_valid, 1'b0);

    // over-long length clamps to DEPTH; Start while busy and Abort in idle are ignored
    start_run(31);
    repeat (5) tick();
    start = 1; prog_len = 5'd2;
    tick();
    start = 0;
    repeat (80) tick();
    chk("clamp_issue", issue_count, 5'd16);
    chk("clamp_pc", pc, 4'd15);
    chk("clamp_instr", instr, 12'h1AF);
    abort = 1;
    tick();
    abort = 0;
    repeat (2) tick();
    chk("idle_abort_instr", instr, 12'h1AF);

    chk_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
